// File: rtl/c7bifu_issue_pkg.sv
// Shared state encodings and types for the IFU issue sequencer.
package c7bifu_issue_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    ISSUE_IDLE     = 2'd0,
    ISSUE_LSU_WAIT = 2'd1,
    ISSUE_SER_WAIT = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [RegAddrW-1:0] rd;
    logic                wen;
  } lsu_tag_t;

  function automatic logic is_wait(input issue_state_e s);
    return (s == ISSUE_LSU_WAIT) || (s == ISSUE_SER_WAIT);
  endfunction

endpackage

// File: rtl/c7bifu_issue_wdt.sv
// Watchdog for the issue wait states; only built when C7BIFU_ISSUE_WDT_EN is defined.
module c7bifu_issue_wdt
  import c7bifu_issue_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = 1024,
  parameter int unsigned WDT_W     = 11
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  issue_state_e state_i,
  output logic         fire_o
);

  logic [WDT_W-1:0] cnt_q, cnt_d;

  // Leaving the wait states always passes through IDLE, so each wait starts from zero.
  always_comb begin
    cnt_d = is_wait(state_i) ? (cnt_q + WDT_W'(1)) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire_o = is_wait(state_i) && (cnt_q == WDT_W'(WDT_LIMIT - 1));

endmodule

// File: rtl/c7bifu_issue_ctl.sv
// Issue sequencer for the IFU decode stage: serialises LSU and CSR/ERTN/exception ops.
// Optional wait-state watchdog is enabled by defining C7BIFU_ISSUE_WDT_EN.
module c7bifu_issue_ctl
  import c7bifu_issue_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = 1024,
  parameter int unsigned WDT_W     = 11,
  parameter int unsigned PERF_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dec_vld_raw_d,
  input  logic              dec_lsu_d,
  input  logic              dec_serial_d,
  input  logic [4:0]        dec_rd_d,
  input  logic              dec_wen_d,
  input  logic              lsu_done_e,
  input  logic              exu_commit_w,
  input  logic              exu_busy,
  input  logic              exu_flush,
  output logic              ctl_stall,
  output logic              ctl_flush,
  output logic              ctl_issue,
  output logic [4:0]        ctl_lsu_rd,
  output logic              ctl_lsu_wen,
  output logic [PERF_W-1:0] ctl_perf_stall,
  output logic              ctl_wdt_err
);

  issue_state_e      state_q, state_d;
  lsu_tag_t          lsu_q, lsu_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              wdt_fire;

  // The last wait count (WDT_LIMIT-1) must be representable in WDT_W bits.
  if ((WDT_LIMIT < 2) || (((WDT_LIMIT - 1) >> WDT_W) != 0)) begin : g_bad_wdt_cfg
    $error("c7bifu_issue_ctl: WDT_W too small for WDT_LIMIT");
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ISSUE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush and watchdog abort override every other transition; LSU wins over serial.
  always_comb begin
    state_d = state_q;
    if (exu_flush || wdt_fire) begin
      state_d = ISSUE_IDLE;
    end else begin
      case (state_q)
        ISSUE_IDLE: begin
          if (ctl_issue && dec_lsu_d) begin
            state_d = ISSUE_LSU_WAIT;
          end else if (ctl_issue && dec_serial_d) begin
            state_d = ISSUE_SER_WAIT;
          end
        end
        ISSUE_LSU_WAIT: begin
          if (lsu_done_e) begin
            state_d = ISSUE_IDLE;
          end
        end
        ISSUE_SER_WAIT: begin
          if (exu_commit_w) begin
            state_d = ISSUE_IDLE;
          end
        end
        default: state_d = ISSUE_IDLE;
      endcase
    end
  end

  // Stall uses only registered state and exu_busy, so no path from dec_* back into decode.
  always_comb begin
    ctl_stall = (state_q != ISSUE_IDLE) | exu_busy;
    ctl_issue = dec_vld_raw_d & ~ctl_stall & ~exu_flush;
    ctl_flush = exu_flush;
  end

  always_comb begin
    lsu_d = '0;
    if (state_d == ISSUE_LSU_WAIT) begin
      if (state_q == ISSUE_IDLE) begin
        lsu_d.rd  = dec_rd_d;
        lsu_d.wen = dec_wen_d & (dec_rd_d != '0);
      end else begin
        lsu_d = lsu_q;
      end
    end
  end

  always_comb begin
    perf_d = perf_q + PERF_W'(ctl_stall & dec_vld_raw_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lsu_q  <= '0;
      perf_q <= '0;
    end else begin
      lsu_q  <= lsu_d;
      perf_q <= perf_d;
    end
  end

`ifdef C7BIFU_ISSUE_WDT_EN
  c7bifu_issue_wdt #(
    .WDT_LIMIT (WDT_LIMIT),
    .WDT_W     (WDT_W)
  ) u_wdt (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .state_i (state_q),
    .fire_o  (wdt_fire)
  );
`else
  assign wdt_fire = 1'b0;
`endif

  assign ctl_lsu_rd     = lsu_q.rd;
  assign ctl_lsu_wen    = lsu_q.wen;
  assign ctl_perf_stall = perf_q;
  assign ctl_wdt_err    = wdt_fire;

endmodule

// File: tb/tb_c7bifu_issue_ctl.sv
// Self-checking bench for c7bifu_issue_ctl: reference model feeds a scoreboard queue.
// Watchdog scenarios follow C7BIFU_ISSUE_WDT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_c7bifu_issue_ctl;

  localparam int unsigned TbWdtLimit = 8;
  localparam int unsigned TbWdtW     = 4;
  localparam int unsigned TbPerfW    = 32;
`ifdef C7BIFU_ISSUE_WDT_EN
  localparam bit WdtOn = 1'b1;
`else
  localparam bit WdtOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        decVld, decLsu, decSerial, decWen;
  logic [4:0]  decRd;
  logic        lsuDone, exuCommit, exuBusy, exuFlush;
  logic        ctlStall, ctlFlush, ctlIssue, ctlLsuWen, ctlWdtErr;
  logic [4:0]  ctlLsuRd;
  logic [TbPerfW-1:0] ctlPerf;

  typedef struct {
    logic        stall;
    logic        issue;
    logic        flush;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] perf;
    logic        wdt;
  } exp_t;

  exp_t expQ[$];

  int          mState;
  logic [4:0]  mRd;
  logic        mWen;
  logic [31:0] mPerf;
  int          mWdt;

  int checks = 0;
  int failures = 0;
  int stallSeen = 0;
  int wdtSeen = 0;
  logic [31:0] perfStart;

  always #5 clk = ~clk;

  c7bifu_issue_ctl #(
    .WDT_LIMIT (TbWdtLimit),
    .WDT_W     (TbWdtW),
    .PERF_W    (TbPerfW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .dec_vld_raw_d  (decVld),
    .dec_lsu_d      (decLsu),
    .dec_serial_d   (decSerial),
    .dec_rd_d       (decRd),
    .dec_wen_d      (decWen),
    .lsu_done_e     (lsuDone),
    .exu_commit_w   (exuCommit),
    .exu_busy       (exuBusy),
    .exu_flush      (exuFlush),
    .ctl_stall      (ctlStall),
    .ctl_flush      (ctlFlush),
    .ctl_issue      (ctlIssue),
    .ctl_lsu_rd     (ctlLsuRd),
    .ctl_lsu_wen    (ctlLsuWen),
    .ctl_perf_stall (ctlPerf),
    .ctl_wdt_err    (ctlWdtErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mRd    = '0;
    mWen   = 1'b0;
    mPerf  = '0;
    mWdt   = 0;
  endtask

  task automatic sampleOutputs();
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput("stall", 32'(ctlStall), 32'(e.stall));
      checkOutput("issue", 32'(ctlIssue), 32'(e.issue));
      checkOutput("flush", 32'(ctlFlush), 32'(e.flush));
      checkOutput("lsu_rd", 32'(ctlLsuRd), 32'(e.rd));
      checkOutput("lsu_wen", 32'(ctlLsuWen), 32'(e.wen));
      checkOutput("perf", ctlPerf, e.perf);
      checkOutput("wdt_err", 32'(ctlWdtErr), 32'(e.wdt));
      if (ctlStall === 1'b1) stallSeen++;
      if (ctlWdtErr === 1'b1) wdtSeen++;
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, check mid-cycle, advance model at posedge.
  task automatic applyStimulus(input logic vld, input logic lsu, input logic serial,
                               input logic [4:0] rd, input logic wen, input logic done,
                               input logic commit, input logic busy, input logic flush);
    exp_t e;
    logic inWait, fire;
    int nState, nWdt;
    logic [4:0] nRd;
    logic nWen;
    @(negedge clk);
    decVld = vld; decLsu = lsu; decSerial = serial; decRd = rd; decWen = wen;
    lsuDone = done; exuCommit = commit; exuBusy = busy; exuFlush = flush;
    inWait  = (mState == 1) || (mState == 2);
    fire    = WdtOn && inWait && (mWdt == int'(TbWdtLimit) - 1);
    e.stall = (mState != 0) || busy;
    e.issue = vld && !e.stall && !flush;
    e.flush = flush;
    e.rd    = mRd;
    e.wen   = mWen;
    e.perf  = mPerf;
    e.wdt   = fire;
    expQ.push_back(e);
    #2 sampleOutputs();
    nState = mState;
    if (flush || fire) nState = 0;
    else if (mState == 0 && e.issue && lsu) nState = 1;
    else if (mState == 0 && e.issue && serial) nState = 2;
    else if (mState == 1 && done) nState = 0;
    else if (mState == 2 && commit) nState = 0;
    nRd  = '0;
    nWen = 1'b0;
    if (nState == 1) begin
      nRd  = (mState == 0) ? rd : mRd;
      nWen = (mState == 0) ? (wen && rd != 5'd0) : mWen;
    end
    nWdt = inWait ? mWdt + 1 : 0;
    @(posedge clk);
    mPerf  = mPerf + ((e.stall && vld) ? 32'd1 : 32'd0);
    mState = nState;
    mRd    = nRd;
    mWen   = nWen;
    mWdt   = nWdt;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"}, 32'(ctlStall), 32'd0);
    checkOutput({tag, "_issue"}, 32'(ctlIssue), 32'd0);
    checkOutput({tag, "_flush"}, 32'(ctlFlush), 32'd0);
    checkOutput({tag, "_rd"}, 32'(ctlLsuRd), 32'd0);
    checkOutput({tag, "_wen"}, 32'(ctlLsuWen), 32'd0);
    checkOutput({tag, "_perf"}, ctlPerf, 32'd0);
    checkOutput({tag, "_wdt"}, 32'(ctlWdtErr), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    decVld = 0; decLsu = 0; decSerial = 0; decRd = '0; decWen = 0;
    lsuDone = 0; exuCommit = 0; exuBusy = 0; exuFlush = 0;
    modelReset();
    #12 checkAllZero("reset");
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] LSU op rd=5 done after 3 wait cycles");
    stallSeen = 0;
    applyStimulus(1, 1, 0, 5'd5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 5'd9, 1, 0, 0, 0, 0);
    #1 checkOutput("lsu_rd_held", 32'(ctlLsuRd), 32'd5);
    checkOutput("lsu_wen_held", 32'(ctlLsuWen), 32'd1);
    applyStimulus(1, 0, 0, 5'd9, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd3, 1, 0, 0, 0, 0);
    checkOutput("lsu_stall_cycles", stallSeen, 4);

    $display("[TB] LSU op rd=0 never enables write-back");
    applyStimulus(1, 1, 0, 5'd0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd4, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 5'd4, 1, 1, 0, 0, 0);

    $display("[TB] CSR op serialises until commit");
    stallSeen = 0;
    perfStart = mPerf;
    applyStimulus(1, 0, 1, 5'd2, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd2, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd2, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd2, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 5'd2, 1, 0, 0, 0, 0);
    checkOutput("csr_stall_cycles", stallSeen, 3);
    #1 checkOutput("csr_perf_delta", ctlPerf - perfStart, 32'd3);

    $display("[TB] flush coincident with LSU done");
    applyStimulus(1, 1, 1, 5'd7, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd7, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 5'd7, 1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 5'd8, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 5'd8, 0, 1, 1, 0, 0);

    $display("[TB] EXU backpressure in IDLE");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 5'd6, 1, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 5'd6, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd6, 1, 0, 0, 1, 1);

    $display("[TB] long LSU wait");
    wdtSeen = 0;
    applyStimulus(1, 1, 0, 5'd11, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 5'd1, 0, 0, 0, 0, 0);
    checkOutput("wdt_pulses", wdtSeen, WdtOn ? 1 : 0);
    applyStimulus(1, 0, 0, 5'd1, 0, 1, 0, 0, 0);

    $display("[TB] reset during SER_WAIT");
    applyStimulus(1, 0, 1, 5'd12, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd12, 1, 0, 0, 0, 0);
    @(negedge clk);
    decVld = 0; decLsu = 0; decSerial = 0; decRd = '0; decWen = 0;
    lsuDone = 0; exuCommit = 0; exuBusy = 0; exuFlush = 0;
    #2 resetn = 1'b0;
    #1 checkAllZero("midreset");
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1, 1, 0, 5'd13, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd13, 1, 1, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                    5'($urandom), 1'($urandom), ($urandom % 4) == 0,
                    ($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 12) == 0);
    end

    checkOutput("sb_drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
